fft_frame_receiver: RTL and testbench



---
 rtl/fft_frame_receiver.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_fft_frame_receiver.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_receiver.sv
// fft_frame_receiver
// Sink-side receiver for the FFT core output stream. Checks frame framing
// against FRAME_LEN, tags each accepted bin with its index and the frame's
// block exponent, buffers beats in a show-ahead FIFO with registered
// backpressure on src_ready, and presents them on a valid/ready port.
// Optional feature macro: FFT_RX_ABS_EN (stores |re|+|im| per entry on out_mag).
module fft_frame_receiver #(
    parameter int DW        = 8,
    parameter int FRAME_LEN = 1024,
    parameter int CNT_W     = 10,
    parameter int EXP_W     = 6,
    parameter int DEPTH     = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             src_valid,
    input  logic             src_sop,
    input  logic             src_eop,
    input  logic [DW-1:0]    src_real,
    input  logic [DW-1:0]    src_imag,
    input  logic [EXP_W-1:0] src_exp,
    input  logic [1:0]       src_error,
    output logic             src_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_real,
    output logic [DW-1:0]    out_imag,
    output logic [CNT_W-1:0] out_bin,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_last,
    output logic [DW:0]      out_mag,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
    output logic             frm_err,
    output logic [2:0]       err_code
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] ZERO_BIN = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_BIN  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(FRAME_LEN - 1);

    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   READY_LIM = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0]   CNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_IN_FRAME = 2'd1;
    localparam logic [1:0] ST_DROP     = 2'd2;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_NO_SOP    = 3'd1;
    localparam logic [2:0] ERR_EARLY_SOP = 3'd2;
    localparam logic [2:0] ERR_SHORT     = 3'd3;
    localparam logic [2:0] ERR_LONG      = 3'd4;
    localparam logic [2:0] ERR_CORE      = 3'd5;

    // Framing state
    logic [1:0]       state_r,   state_nxt_s;
    logic [CNT_W-1:0] bin_cnt_r, bin_nxt_s;
    logic [EXP_W-1:0] exp_r,     exp_nxt_s;

    // Decoded beat actions
    logic             accept_s;
    logic             push_s;
    logic [CNT_W-1:0] push_bin_s;
    logic [EXP_W-1:0] push_exp_s;
    logic             push_last_s;
    logic             err_s;
    logic [2:0]       err_code_s;

    // FIFO control
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]   count_r, count_nxt_s;
    logic             fifo_push_s, fifo_pop_s;
    logic             out_valid_r, src_ready_r;

    // FIFO storage
    logic [DW-1:0]    real_mem [DEPTH];
    logic [DW-1:0]    imag_mem [DEPTH];
    logic [CNT_W-1:0] bin_mem  [DEPTH];
    logic [EXP_W-1:0] exp_mem  [DEPTH];
    logic             last_mem [DEPTH];

    // Status registers
    logic             frame_done_r, frm_err_r;
    logic [15:0]      frame_cnt_r;
    logic [2:0]       err_code_r;
    logic             done_s;

    // Decode each accepted beat into push / error / next framing state
    always_comb begin
        accept_s    = src_valid && src_ready_r;
        push_s      = 1'b0;
        push_bin_s  = bin_cnt_r;
        push_exp_s  = exp_r;
        push_last_s = 1'b0;
        err_s       = 1'b0;
        err_code_s  = ERR_NONE;
        state_nxt_s = state_r;
        bin_nxt_s   = bin_cnt_r;
        exp_nxt_s   = exp_r;
        if (accept_s) begin
            if (src_error != 2'b00) begin
                // Core errors override any framing error on the same beat
                err_s       = 1'b1;
                err_code_s  = ERR_CORE;
                state_nxt_s = ST_DROP;
                bin_nxt_s   = ZERO_BIN;
            end else if (src_sop) begin
                if (src_eop && (LAST_BIN != ZERO_BIN)) begin
                    // One-beat frame: short; inside a frame the early sop is reported
                    err_s       = 1'b1;
                    err_code_s  = (state_r == ST_IN_FRAME) ? ERR_EARLY_SOP : ERR_SHORT;
                    state_nxt_s = ST_IDLE;
                    bin_nxt_s   = ZERO_BIN;
                end else begin
                    err_s       = (state_r == ST_IN_FRAME);
                    err_code_s  = (state_r == ST_IN_FRAME) ? ERR_EARLY_SOP : ERR_NONE;
                    push_s      = 1'b1;
                    push_bin_s  = ZERO_BIN;
                    push_exp_s  = src_exp;
                    exp_nxt_s   = src_exp;
                    push_last_s = (LAST_BIN == ZERO_BIN);
                    if (LAST_BIN == ZERO_BIN) begin
                        state_nxt_s = ST_IDLE;
                        bin_nxt_s   = ZERO_BIN;
                    end else begin
                        state_nxt_s = ST_IN_FRAME;
                        bin_nxt_s   = ONE_BIN;
                    end
                end
            end else begin
                case (state_r)
                    ST_IN_FRAME: begin
                        if (src_eop) begin
                            state_nxt_s = ST_IDLE;
                            bin_nxt_s   = ZERO_BIN;
                            if (bin_cnt_r == LAST_BIN) begin
                                push_s      = 1'b1;
                                push_last_s = 1'b1;
                            end else begin
                                err_s      = 1'b1;
                                err_code_s = ERR_SHORT;
                            end
                        end else if (bin_cnt_r == LAST_BIN) begin
                            err_s       = 1'b1;
                            err_code_s  = ERR_LONG;
                            state_nxt_s = ST_DROP;
                            bin_nxt_s   = ZERO_BIN;
                        end else begin
                            push_s    = 1'b1;
                            bin_nxt_s = bin_cnt_r + ONE_BIN;
                        end
                    end
                    ST_IDLE: begin
                        err_s      = 1'b1;
                        err_code_s = ERR_NO_SOP;
                    end
                    ST_DROP: begin
                        state_nxt_s = ST_DROP;
                    end
                    default: begin
                        state_nxt_s = ST_IDLE;
                        bin_nxt_s   = ZERO_BIN;
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FIFO occupancy arithmetic
    always_comb begin
        fifo_pop_s  = out_valid_r && out_ready;
        fifo_push_s = push_s && ((count_r != DEPTH_CNT) || fifo_pop_s);
        done_s      = fifo_pop_s && last_mem[rd_ptr_r];
        case ({fifo_push_s, fifo_pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Framing state, bin counter and latched frame exponent
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            bin_cnt_r <= ZERO_BIN;
            exp_r     <= {EXP_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            bin_cnt_r <= bin_nxt_s;
            exp_r     <= exp_nxt_s;
        end
    end

    // FIFO pointers, occupancy, head-valid flag and registered backpressure
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {(PTR_W+1){1'b0}};
            out_valid_r <= 1'b0;
            src_ready_r <= 1'b0;
        end else begin
            if (fifo_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != {(PTR_W+1){1'b0}});
            // Leaves room for the one beat that can land while ready drops
            src_ready_r <= (count_nxt_s <= READY_LIM);
        end
    end

    // FIFO entry storage; cleared on reset so the idle head reads as zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                real_mem[i] <= {DW{1'b0}};
                imag_mem[i] <= {DW{1'b0}};
                bin_mem[i]  <= ZERO_BIN;
                exp_mem[i]  <= {EXP_W{1'b0}};
                last_mem[i] <= 1'b0;
            end
        end else if (fifo_push_s) begin
            real_mem[wr_ptr_r] <= src_real;
            imag_mem[wr_ptr_r] <= src_imag;
            bin_mem[wr_ptr_r]  <= push_bin_s;
            exp_mem[wr_ptr_r]  <= push_exp_s;
            last_mem[wr_ptr_r] <= push_last_s;
        end
    end

    // Error pulse and sticky last-error code
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frm_err_r  <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            frm_err_r <= err_s;
            if (err_s) begin
                err_code_r <= err_code_s;
            end
        end
    end

    // Good-frame completion; only frames that reached a clean eop carry a last beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_done_r <= 1'b0;
            frame_cnt_r  <= 16'd0;
        end else begin
            frame_done_r <= done_s;
            if (done_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
        end
    end

`ifdef FFT_RX_ABS_EN
    logic [DW:0] mag_mem [DEPTH];
    logic [DW:0] mag_s;

    // Magnitude of a two's complement value, one bit wider so -2^(DW-1) fits
    function automatic logic [DW:0] abs_ext(input logic [DW-1:0] v);
        if (v[DW-1]) begin
            abs_ext = {1'b0, ~v} + {{DW{1'b0}}, 1'b1};
        end else begin
            abs_ext = {1'b0, v};
        end
    endfunction

    // L1 magnitude of the incoming beat
    always_comb begin
        mag_s = abs_ext(src_real) + abs_ext(src_imag);
    end

    // Magnitude stored alongside each FIFO entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mag_mem[i] <= {(DW+1){1'b0}};
            end
        end else if (fifo_push_s) begin
            mag_mem[wr_ptr_r] <= mag_s;
        end
    end

    assign out_mag = mag_mem[rd_ptr_r];
`else
    assign out_mag = {(DW+1){1'b0}};
`endif

    assign src_ready  = src_ready_r;
    assign out_valid  = out_valid_r;
    assign out_real   = real_mem[rd_ptr_r];
    assign out_imag   = imag_mem[rd_ptr_r];
    assign out_bin    = bin_mem[rd_ptr_r];
    assign out_exp    = exp_mem[rd_ptr_r];
    assign out_last   = last_mem[rd_ptr_r];
    assign frame_done = frame_done_r;
    assign frame_cnt  = frame_cnt_r;
    assign frm_err    = frm_err_r;
    assign err_code   = err_code_r;

endmodule

// File: tb/tb_fft_frame_receiver.sv
// Self-checking bench for fft_frame_receiver with FRAME_LEN=8, DEPTH=4.
// Expected beats are queued when accepted and compared as they are popped.
module tb_fft_frame_receiver;

    localparam int DW    = 8;
    localparam int FL    = 8;
    localparam int CW    = 3;
    localparam int EW    = 6;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          src_valid, src_sop, src_eop;
    logic [DW-1:0] src_real, src_imag;
    logic [EW-1:0] src_exp;
    logic [1:0]    src_error;
    logic          src_ready, out_valid, out_ready;
    logic [DW-1:0] out_real, out_imag;
    logic [CW-1:0] out_bin;
    logic [EW-1:0] out_exp;
    logic          out_last;
    logic [DW:0]   out_mag;
    logic          frame_done, frm_err;
    logic [15:0]   frame_cnt;
    logic [2:0]    err_code;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [CW-1:0] bin;
        logic [EW-1:0] ex;
        logic          last;
        logic [DW:0]   mag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   err_pulses = 0;
    logic m_done = 1'b0;
    int   m_cnt = 0;

    always #5 clk = ~clk;

    fft_frame_receiver #(
        .DW(DW), .FRAME_LEN(FL), .CNT_W(CW), .EXP_W(EW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_real(src_real), .src_imag(src_imag), .src_exp(src_exp),
        .src_error(src_error), .src_ready(src_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag), .out_bin(out_bin),
        .out_exp(out_exp), .out_last(out_last), .out_mag(out_mag),
        .frame_done(frame_done), .frame_cnt(frame_cnt),
        .frm_err(frm_err), .err_code(err_code)
    );

    function automatic logic [DW:0] mag_of(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int a;
        int b;
        a = int'($signed(re));
        b = int'($signed(im));
        if (a < 0) a = -a;
        if (b < 0) b = -b;
`ifdef FFT_RX_ABS_EN
        return 9'(a + b);
`else
        return 9'(0 * (a + b));
`endif
    endfunction

    // Output monitor: scoreboard pops, frame_done / frame_cnt model, error pulse count
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            m_done = 1'b0;
            m_cnt  = 0;
        end else begin
            checks++;
            if (frame_done !== m_done) begin
                errors++;
                $display("FAIL frame_done got %0b expected %0b at %0t", frame_done, m_done, $time);
            end
            checks++;
            if (frame_cnt !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL frame_cnt got %0d expected %0d at %0t", frame_cnt, m_cnt, $time);
            end
            m_done = 1'b0;
            if (frm_err === 1'b1) err_pulses++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got bin %0d re %0d at %0t", out_bin, out_real, $time);
                end else begin
                    e = sb.pop_front();
                    if (out_real !== e.re || out_imag !== e.im || out_bin !== e.bin ||
                        out_exp !== e.ex || out_last !== e.last || out_mag !== e.mag) begin
                        errors++;
                        $display("FAIL beat got re %0d im %0d bin %0d exp %0d last %0b mag %0d expected re %0d im %0d bin %0d exp %0d last %0b mag %0d",
                                 out_real, out_imag, out_bin, out_exp, out_last, out_mag,
                                 e.re, e.im, e.bin, e.ex, e.last, e.mag);
                    end
                    if (e.last) begin
                        m_done = 1'b1;
                        m_cnt++;
                    end
                end
            end
        end
    end

    // Drive one beat (called right after a rising edge); queue it if it should be delivered
    task automatic send(input logic sop, input logic eop, input logic [DW-1:0] re,
                        input logic [DW-1:0] im, input logic [EW-1:0] ex, input logic [1:0] er,
                        input bit keep, input logic [CW-1:0] bin, input logic [EW-1:0] fexp);
        exp_t e;
        int n;
        src_valid = 1'b1; src_sop = sop; src_eop = eop;
        src_real = re; src_imag = im; src_exp = ex; src_error = er;
        n = 0;
        @(negedge clk);
        while (src_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got src_ready %0b expected 1", src_ready);
        end else if (keep) begin
            e.re = re; e.im = im; e.bin = bin; e.ex = fexp;
            e.last = (bin == 3'd7); e.mag = mag_of(re, im);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0; src_error = 2'b00;
    endtask

    // Clean frame: re=base+k, im=-(base+k); src_exp differs off the sop beat
    task automatic send_frame(input int base, input logic [EW-1:0] ex);
        for (int k = 0; k < FL; k++) begin
            send(k == 0, k == FL - 1, 8'(base + k), 8'(-(base + k)),
                 (k == 0) ? ex : 6'(ex + k + 1), 2'b00, 1'b1, 3'(k), ex);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", sb.size());
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic check_status(input string name, input logic [2:0] code, input int pulses, input int cnt);
        checks++;
        if (err_code !== code) begin
            errors++;
            $display("FAIL %s err_code got %0d expected %0d", name, err_code, code);
        end
        checks++;
        if (err_pulses !== pulses) begin
            errors++;
            $display("FAIL %s frm_err pulses got %0d expected %0d", name, err_pulses, pulses);
        end
        checks++;
        if (frame_cnt !== 16'(cnt)) begin
            errors++;
            $display("FAIL %s frame_cnt got %0d expected %0d", name, frame_cnt, cnt);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; out_ready = 1'b1;
        src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0;
        src_real = 8'd0; src_imag = 8'd0; src_exp = 6'd0; src_error = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({src_ready, out_valid, frame_done, frm_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 0000", {src_ready, out_valid, frame_done, frm_err});
        end
        checks++;
        if (frame_cnt !== 16'd0 || err_code !== 3'd0) begin
            errors++;
            $display("FAIL reset_status got cnt %0d code %0d expected 0 0", frame_cnt, err_code);
        end
        checks++;
        if ({out_real, out_imag, out_bin, out_exp, out_last, out_mag} !== 35'd0) begin
            errors++;
            $display("FAIL reset_data got nonzero head expected 0");
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (src_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_first got %0b expected 0", src_ready);
        end
        @(negedge clk);
        checks++;
        if (src_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_second got %0b expected 1", src_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clean();
        send_frame(0, 6'd5);
        wait_drain();
        check_status("clean", 3'd0, 0, 1);
    endtask

    task automatic test_short();
        int p0;
        p0 = err_pulses;
        for (int k = 0; k < 6; k++) begin
            send(k == 0, k == 5, 8'(20 + k), 8'(k), 6'd9, 2'b00, k < 5, 3'(k), 6'd9);
        end
        wait_drain();
        check_status("short", 3'd3, p0 + 1, 1);
        send_frame(32, 6'd9);
        wait_drain();
        check_status("short_next", 3'd3, p0 + 1, 2);
    endtask

    task automatic test_long();
        int p0;
        p0 = err_pulses;
        for (int k = 0; k < 11; k++) begin
            send(k == 0, k == 10, 8'(40 + k), 8'(-k), 6'd3, 2'b00, k < 7, 3'(k), 6'd3);
        end
        wait_drain();
        check_status("long", 3'd4, p0 + 1, 2);
        send_frame(64, 6'd3);
        wait_drain();
        check_status("long_next", 3'd4, p0 + 1, 3);
    endtask

    task automatic test_nosop_early();
        int p0;
        p0 = err_pulses;
        send(1'b0, 1'b0, 8'd1, 8'd2, 6'd0, 2'b00, 1'b0, 3'd0, 6'd0);
        wait_drain();
        check_status("no_sop", 3'd1, p0 + 1, 3);
        for (int k = 0; k < 3; k++) begin
            send(k == 0, 1'b0, 8'(90 + k), 8'(k), 6'd17, 2'b00, 1'b1, 3'(k), 6'd17);
        end
        send_frame(100, 6'd7);
        wait_drain();
        check_status("early_sop", 3'd2, p0 + 2, 4);
    endtask

    task automatic test_core();
        int p0;
        p0 = err_pulses;
        for (int k = 0; k < 6; k++) begin
            send(k == 0 || k == 3, 1'b0, 8'(80 + k), 8'(k), 6'd21, (k == 3) ? 2'b01 : 2'b00,
                 k < 3, 3'(k), 6'd21);
        end
        wait_drain();
        check_status("core", 3'd5, p0 + 1, 4);
        send_frame(110, 6'd2);
        wait_drain();
        check_status("core_next", 3'd5, p0 + 1, 5);
    endtask

    task automatic test_mag();
        for (int k = 0; k < FL; k++) begin
            send(k == 0, k == FL - 1, (k == 2) ? 8'h80 : 8'(k), (k == 2) ? 8'h7F : 8'(-k * 5),
                 6'd1, 2'b00, 1'b1, 3'(k), 6'd1);
        end
        wait_drain();
        check_status("mag", 3'd5, err_pulses, 6);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int k;
        int cyc;
        int acc_hold;
        k = 0; cyc = 0; acc_hold = 0;
        while (k < FL && cyc < 100) begin
            out_ready = (cyc >= 12);
            src_valid = 1'b1; src_sop = (k == 0); src_eop = (k == FL - 1);
            src_real = 8'(k + 16); src_imag = 8'(k * 3); src_exp = 6'd11; src_error = 2'b00;
            @(negedge clk);
            if (cyc == 10) begin
                checks++;
                if (src_ready !== 1'b0 || out_valid !== 1'b1 || out_bin !== 3'd0) begin
                    errors++;
                    $display("FAIL hold got ready %0b valid %0b bin %0d expected 0 1 0", src_ready, out_valid, out_bin);
                end
            end
            if (src_ready === 1'b1) begin
                e.re = src_real; e.im = src_imag; e.bin = 3'(k); e.ex = 6'd11;
                e.last = (k == FL - 1); e.mag = mag_of(src_real, src_imag);
                sb.push_back(e);
                k++;
                if (cyc < 12) acc_hold++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (acc_hold !== DEPTH - 1) begin
            errors++;
            $display("FAIL fill_level got %0d expected %0d", acc_hold, DEPTH - 1);
        end
        checks++;
        if (k !== FL) begin
            errors++;
            $display("FAIL bp_sent got %0d expected %0d", k, FL);
        end
        wait_drain();
        check_status("back_to_back", 3'd5, err_pulses, 7);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(k == 0, 1'b0, 8'(k), 8'(k), 6'd30, 2'b00, 1'b0, 3'(k), 6'd30);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid got %0b expected 1", out_valid);
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || src_ready !== 1'b0 || out_bin !== 3'd0) begin
            errors++;
            $display("FAIL async_reset got valid %0b ready %0b bin %0d expected 0 0 0", out_valid, src_ready, out_bin);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (src_ready !== 1'b0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL in_reset got ready %0b cnt %0d expected 0 0", src_ready, frame_cnt);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        send_frame(7, 6'd4);
        wait_drain();
        check_status("after_reset", 3'd0, err_pulses, 1);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_short();
        test_long();
        test_nosop_early();
        test_core();
        test_mag();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
